// File: rtl/fsk_demod.sv
// FSK demodulator: measures the spacing of FSK edges, votes mark/space per bit
// period and emits one decided bit per period once a valid carrier is locked.
module fsk_demod #(
  parameter int unsigned HALF_MARK  = 2,
  parameter int unsigned HALF_SPACE = 4,
  parameter int unsigned BIT_CYCLES = 16,
  parameter int unsigned LOCK_EDGES = 4
) (
  input  logic tx_clk,
  input  logic reset,
  input  logic fsk_in,
  output logic rx_data,
  output logic rx_valid,
  output logic carrier,
  output logic err
);

  localparam int unsigned TIMEOUT   = 2 * HALF_SPACE + 1;
  localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1);
  localparam int unsigned THRESH    = (HALF_MARK + HALF_SPACE) / 2;
  localparam int unsigned SPACE_MAX = HALF_SPACE + 1;
  localparam int unsigned BIT_W     = $clog2(BIT_CYCLES);
  localparam int unsigned LOCK_W    = $clog2(LOCK_EDGES + 1);
  localparam int unsigned ACC_W     = $clog2(2 * BIT_CYCLES + 2 * TIMEOUT + 1);

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Front end: two-flop synchronizer plus one delay flop for edge detect
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] ivl_q, ivl_d;
  logic             edge_c;
  logic             timeout_c;
  logic             is_mark_c;
  logic             is_valid_c;
  logic             loss_c;

  state_t           state_q, state_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [ACC_W-1:0] mark_q, mark_d;
  logic [ACC_W-1:0] space_q, space_d;
  logic [ACC_W-1:0] mark_sum_c, space_sum_c;
  logic [ACC_W-1:0] ivl_ext_c;
  logic             prev_mark_q, prev_mark_d;
  logic             data_d, valid_d, err_d;

  always_ff @(posedge tx_clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 3'b000;
      ivl_q  <= '0;
    end else begin
      sync_q <= {sync_q[1:0], fsk_in};
      ivl_q  <= ivl_d;
    end
  end

  // Interval counter holds the clocks since the previous edge, edge cycle included
  always_comb begin
    edge_c     = sync_q[1] ^ sync_q[2];
    timeout_c  = !edge_c && (ivl_q == CNT_W'(TIMEOUT));
    is_mark_c  = ivl_q < CNT_W'(THRESH);
    is_valid_c = ivl_q <= CNT_W'(SPACE_MAX);
    loss_c     = (edge_c && !is_valid_c) || timeout_c;
    ivl_ext_c  = ACC_W'(ivl_q);
    if (edge_c) begin
      ivl_d = CNT_W'(1);
    end else if (ivl_q == CNT_W'(TIMEOUT)) begin
      ivl_d = ivl_q;
    end else begin
      ivl_d = ivl_q + CNT_W'(1);
    end
  end

  always_ff @(posedge tx_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT;
      lock_q      <= '0;
      bit_q       <= '0;
      mark_q      <= '0;
      space_q     <= '0;
      prev_mark_q <= 1'b0;
      rx_data     <= 1'b0;
      rx_valid    <= 1'b0;
      carrier     <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      bit_q       <= bit_d;
      mark_q      <= mark_d;
      space_q     <= space_d;
      prev_mark_q <= prev_mark_d;
      rx_data     <= data_d;
      rx_valid    <= valid_d;
      carrier     <= (state_d == TRACK);
      err         <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    bit_d       = bit_q;
    mark_d      = mark_q;
    space_d     = space_q;
    prev_mark_d = prev_mark_q;
    data_d      = rx_data;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    // Votes including the current edge, used on ordinary (same-class) cycles
    mark_sum_c  = mark_q + ((edge_c && is_mark_c) ? ivl_ext_c : '0);
    space_sum_c = space_q + ((edge_c && !is_mark_c) ? ivl_ext_c : '0);

    unique case (state_q)
      HUNT: begin
        if (edge_c) begin
          if (is_valid_c) begin
            if (lock_q == LOCK_W'(LOCK_EDGES - 1)) begin
              state_d     = TRACK;
              lock_d      = '0;
              bit_d       = '0;
              mark_d      = '0;
              space_d     = '0;
              prev_mark_d = is_mark_c;
            end else begin
              lock_d = lock_q + LOCK_W'(1);
            end
          end else begin
            lock_d = '0;
          end
        end else if (timeout_c) begin
          lock_d = '0;
        end
      end

      TRACK: begin
        if (loss_c) begin
          state_d = HUNT;
          lock_d  = '0;
          bit_d   = '0;
          mark_d  = '0;
          space_d = '0;
          err_d   = 1'b1;
        end else if (edge_c && (is_mark_c != prev_mark_q)) begin
          // Class change realigns bit timing; late enough in the bit to decide
          prev_mark_d = is_mark_c;
          bit_d       = '0;
          if (bit_q >= BIT_W'(BIT_CYCLES / 2)) begin
            valid_d = 1'b1;
            data_d  = (mark_q > space_q);
          end
          mark_d  = is_mark_c ? ivl_ext_c : '0;
          space_d = is_mark_c ? '0 : ivl_ext_c;
        end else if (bit_q == BIT_W'(BIT_CYCLES - 1)) begin
          valid_d = 1'b1;
          data_d  = (mark_sum_c > space_sum_c);
          bit_d   = '0;
          mark_d  = '0;
          space_d = '0;
        end else begin
          bit_d   = bit_q + BIT_W'(1);
          mark_d  = mark_sum_c;
          space_d = space_sum_c;
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase
  end

endmodule

// File: tb/tb_fsk_demod.sv
// Directed bench for fsk_demod: per-record waveform levels with hand-derived
// output expectations at every clock, plus reset sequences.
module tb_fsk_demod;

  logic tx_clk = 1'b0;
  logic reset  = 1'b0;
  logic fsk_in = 1'b0;
  logic rx_data, rx_valid, carrier, err;

  always #5 tx_clk = ~tx_clk;

  fsk_demod dut (
    .tx_clk   (tx_clk),
    .reset    (reset),
    .fsk_in   (fsk_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .carrier  (carrier),
    .err      (err)
  );

  // One record: hold fsk_in at lvl for hold clocks; outputs expected constant
  typedef struct {
    logic        lvl;
    int unsigned hold;
    logic        v;
    logic        d;
    logic        c;
    logic        e;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   phase    = 0;
  int   step     = 0;

  function automatic void add(logic lvl, int unsigned hold, logic v, logic d, logic c, logic e);
    vec_t r;
    r.lvl  = lvl;
    r.hold = hold;
    r.v    = v;
    r.d    = d;
    r.c    = c;
    r.e    = e;
    vecs.push_back(r);
  endfunction

  // count alternating half-periods of length hold, no strobe, no error
  function automatic void run(logic start, int unsigned hold, int unsigned count, logic d, logic c);
    for (int unsigned i = 0; i < count; i++) begin
      add(start ^ logic'(i % 2), hold, 1'b0, d, c, 1'b0);
    end
  endfunction

  // Long idle then mark toggling: first edge is invalid, lock on the 5th edge
  function automatic void lock_prefix();
    run(1'b1, 2, 5, 1'b0, 1'b0);        // steps 0-9
    add(1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0); // step 10: carrier up
    add(1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0); // step 11
  endfunction

  // Lock, mark until step 20, then hold high through the first bit decision
  function automatic void hold_prefix();
    lock_prefix();
    run(1'b1, 2, 4, 1'b0, 1'b1);        // steps 12-19
    add(1'b1, 6, 1'b0, 1'b0, 1'b1, 1'b0); // steps 20-25
    add(1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b0); // step 26: boundary decision = 1
  endfunction

  function automatic void mark_table();
    lock_prefix();
    run(1'b1, 2, 7, 1'b0, 1'b1);        // steps 12-25
    add(1'b0, 1, 1'b1, 1'b1, 1'b1, 1'b0); // step 26
    add(1'b0, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    run(1'b1, 2, 7, 1'b1, 1'b1);        // steps 28-41
    add(1'b0, 1, 1'b1, 1'b1, 1'b1, 1'b0); // step 42
    add(1'b0, 1, 1'b0, 1'b1, 1'b1, 1'b0);
  endfunction

  task automatic check(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL phase %0d step %0d %s: got %b expected %b", phase, step, name, act, exp);
    end
  endtask

  task automatic check_all(logic v, logic d, logic c, logic e);
    check("rx_valid", rx_valid, v);
    check("rx_data", rx_data, d);
    check("carrier", carrier, c);
    check("err", err, e);
  endtask

  task automatic tick();
    @(posedge tx_clk);
    #1;
  endtask

  task automatic apply_table();
    step = 0;
    foreach (vecs[i]) begin
      for (int unsigned k = 0; k < vecs[i].hold; k++) begin
        fsk_in = vecs[i].lvl;
        tick();
        check_all(vecs[i].v, vecs[i].d, vecs[i].c, vecs[i].e);
        step++;
      end
    end
    vecs.delete();
  endtask

  // Reset then a quiet line: HUNT never raises err on silence
  task automatic reset_idle();
    reset  = 1'b0;
    fsk_in = 1'b0;
    step   = -100;
    repeat (3) begin
      tick();
      check_all(1'b0, 1'b0, 1'b0, 1'b0);
      step++;
    end
    reset = 1'b1;
    repeat (12) begin
      tick();
      check_all(1'b0, 1'b0, 1'b0, 1'b0);
      step++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    phase = 0;
    reset_idle();

    // Steady mark: strobe every 16 clocks with data 1
    phase = 1;
    mark_table();
    apply_table();

    // Bits 1,0,1,1,0 with a trailing mark edge to close the last space bit
    phase = 2;
    reset_idle();
    lock_prefix();
    run(1'b1, 2, 6, 1'b0, 1'b1);         // steps 12-23
    add(1'b1, 2, 1'b0, 1'b0, 1'b1, 1'b0); // steps 24-25
    add(1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b0); // step 26: 1
    add(1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    run(1'b0, 4, 3, 1'b1, 1'b1);         // steps 28-39
    run(1'b1, 2, 2, 1'b1, 1'b1);         // steps 40-43
    add(1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b0); // step 44: 0
    add(1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    run(1'b0, 2, 7, 1'b0, 1'b1);         // steps 46-59
    add(1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b0); // step 60: 1
    add(1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    run(1'b0, 2, 5, 1'b1, 1'b1);         // steps 62-71
    add(1'b1, 4, 1'b0, 1'b1, 1'b1, 1'b0); // steps 72-75
    add(1'b0, 1, 1'b1, 1'b1, 1'b1, 1'b0); // step 76: 1
    add(1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b0);
    run(1'b1, 4, 2, 1'b1, 1'b1);         // steps 80-87
    add(1'b1, 2, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 2, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b0); // step 92: 0
    add(1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    apply_table();

    // 7-clock interval in TRACK: err pulse, carrier drop, relock on 4 edges
    phase = 3;
    reset_idle();
    hold_prefix();
    add(1'b0, 1, 1'b0, 1'b1, 1'b1, 1'b0); // step 27: interval 7 transition
    add(1'b0, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b1); // step 29: loss
    add(1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    run(1'b0, 2, 3, 1'b1, 1'b0);         // steps 31-36
    add(1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b0); // step 37: relocked
    add(1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    apply_table();

    // Silence in TRACK: timeout on the 9th edge-free clock, data held
    phase = 4;
    reset_idle();
    hold_prefix();
    add(1'b1, 4, 1'b0, 1'b1, 1'b1, 1'b0);  // steps 27-30
    add(1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b1);  // step 31: timeout
    add(1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_table();

    // Asynchronous reset mid-bit, then a full relock from scratch
    phase = 5;
    reset_idle();
    lock_prefix();
    run(1'b1, 2, 7, 1'b0, 1'b1);
    add(1'b0, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    run(1'b1, 2, 3, 1'b1, 1'b1);         // steps 28-33, mid-bit
    apply_table();
    #3;
    reset = 1'b0;
    #1;
    step = -1;
    check_all(1'b0, 1'b0, 1'b0, 1'b0);
    reset_idle();
    phase = 6;
    mark_table();
    apply_table();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsk_demod.md
# fsk_demod

FSK demodulator: the receive end of the FSK modem. It recovers the serial bit stream from the square-wave FSK_OUT produced by the modulator under the 10 MHz modem clock. It measures the spacing between FSK edges, classifies each half-period as mark (1) or space (0), locks onto a valid carrier and emits one decided bit per bit period with a valid strobe.

## Interface
- HALF_MARK, 2: half-period of a mark (1) tone, in clocks
- HALF_SPACE, 4: half-period of a space (0) tone, in clocks; must be ≥ HALF_MARK+2
- BIT_CYCLES, 16: clocks per data bit
- LOCK_EDGES, 4: consecutive valid intervals required to declare carrier
- TX_CLK  input  1  modem clock, 10 MHz, all logic on rising edge
- RESET  input  1  asynchronous, active-low reset
- FSK_IN  input  1  FSK waveform from the modulator, asynchronous to sampling
- RX_DATA  output  1  last decided bit, held between strobes
- RX_VALID  output  1  one-cycle strobe: RX_DATA updated this cycle
- CARRIER  output  1  high while in TRACK
- ERR  output  1  one-cycle pulse on carrier loss

## Operation
- Front end: 2-flop synchronizer on FSK_IN, then a third flop for edge detect. An edge is either polarity and is a single-cycle internal pulse.
- Interval counter: counts clocks since the last edge. Saturates at TIMEOUT = 2*HALF_SPACE+1. Width is $clog2(TIMEOUT+1). On an edge, the interval includes the edge cycle, then the counter restarts at 1.
- Classification at each edge, with THRESH = (HALF_MARK+HALF_SPACE)/2, integer division:
  - interval < THRESH: mark.
  - THRESH ≤ interval ≤ HALF_SPACE+1: space.
  - Otherwise: invalid.
  - Defaults: mark 1–2, space 3–5, invalid ≥6.
- State HUNT (reset state):
  - Count consecutive valid intervals of either class.
  - An invalid interval or timeout clears the count.
  - At LOCK_EDGES valid intervals, go to TRACK on that edge. The bit accumulator and bit counter are cleared and the current class is recorded.
- State TRACK:
  - Bit counter increments every clock.
  - Each classified interval adds its length to mark_acc or space_acc.
  - Bit decision: RX_DATA = (mark_acc > space_acc); a tie decides 0. On a decision, RX_VALID pulses, the accumulators clear and the bit counter restarts.
  - Normal boundary: decide when the bit counter reaches BIT_CYCLES-1.
  - Class-change edge (class differs from the previous edge): realigns bit timing.
    - If bit counter ≥ BIT_CYCLES/2, decide on the accumulated votes, excluding the new edge.
    - Otherwise discard the accumulators.
    - In either case, restart the bit counter at 0 and seed the accumulators with the new edge's interval.
    - If a class change and the normal boundary coincide, exactly one decision is made (class-change rule).
  - Invalid interval or timeout: go to HUNT, CARRIER=0, ERR pulse, no RX_VALID that cycle. Partial votes are discarded.
- Reset (any time, including mid-bit): state HUNT, all counters and accumulators 0, synchronizer flops 0.

## Timing
- Reset values: RX_DATA=0, RX_VALID=0, CARRIER=0, ERR=0.
- FSK_IN transition sampled at clock k produces the edge pulse at clock k+2.
- Classification and state update happen on the same clock as the edge pulse.
- CARRIER rises on the clock after the LOCK_EDGES-th valid edge is registered. It falls on the clock after the loss event, in the same cycle ERR is high.
- RX_VALID and RX_DATA are registered and change together. RX_VALID never stays high for 2 consecutive cycles unless a class-change decision immediately follows a boundary decision.
- Steady single-tone input gives RX_VALID every BIT_CYCLES clocks.
- Timeout fires when the interval counter reaches TIMEOUT without an edge (default: 9th edge-free clock).

## Test plan
- Reset and idle: assert RESET low mid-stream, hold FSK_IN=0 → all outputs 0, CARRIER stays 0; release, no edges → no ERR (HUNT does not pulse ERR).
- Mark lock: toggle FSK_IN every 2 clocks → CARRIER high after 4th edge (+2 sync); thereafter RX_VALID every 16 clocks with RX_DATA=1.
- Pattern 1,0,1,1,0 (16 clocks per bit, half-periods 2/4), preceded by 4 mark half-periods → after lock, RX_DATA sequence 1,0,1,1,0 aligned to class-change edges; no ERR.
- Invalid interval: in TRACK, hold FSK_IN for 7 clocks then resume → ERR one cycle, CARRIER=0, no RX_VALID; relock after 4 valid edges.
- Silence: in TRACK, stop toggling → ERR and CARRIER fall on the 9th edge-free clock; RX_DATA holds its last value.
- Reset mid-bit in TRACK → outputs return to reset values asynchronously; no RX_VALID until relock plus a full bit.
